serial_subtractor: RTL and testbench



---
 rtl/serial_subtractor.sv | 91 +++++++++
 tb/tb_serial_subtractor.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes a - b LSB-first, one bit slice per clock,
// with a start/busy/done handshake and a single operation in flight.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] sh_a, sh_b, res, res_next;
    logic             borrow, borrow_next, bit_d, last_bit;
    logic [CW-1:0]    cnt;

    // Handshake: start is only sampled while busy=0; done is a one-cycle
    // pulse in DONE, during which diff/bout already hold the new result.
    assign busy = (state != IDLE);
    assign done = (state == DONE);

    assign last_bit = (cnt == CW'(WIDTH - 1));

    always_comb begin
        state_next  = state;
        bit_d       = sh_a[0] ^ sh_b[0] ^ borrow;
        borrow_next = (~sh_a[0] & sh_b[0]) | (~(sh_a[0] ^ sh_b[0]) & borrow);
        // Written as shift-then-insert so it also holds for WIDTH=1.
        res_next            = res >> 1;
        res_next[WIDTH-1]   = bit_d;
        case (state)
            IDLE:    if (start) state_next = SHIFT;
            SHIFT:   if (last_bit) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            sh_a   <= '0;
            sh_b   <= '0;
            res    <= '0;
            borrow <= 1'b0;
            cnt    <= '0;
            diff   <= '0;
            bout   <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (start) begin
                        sh_a   <= a;
                        sh_b   <= b;
                        borrow <= 1'b0;
                        cnt    <= '0;
                        res    <= '0;
                    end
                end
                SHIFT: begin
                    res    <= res_next;
                    sh_a   <= sh_a >> 1;
                    sh_b   <= sh_b >> 1;
                    borrow <= borrow_next;
                    cnt    <= cnt + 1'b1;
                    // Publish only the complete result, never partial bits.
                    if (last_bit) begin
                        diff <= res_next;
                        bout <= borrow_next;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor: an 8-bit instance and a 1-bit instance
// share one clock; expected values are hand-computed constants.
module tb_serial_subtractor;

    logic       clk;
    logic       rst_n;

    logic       start8;
    logic [7:0] a8, b8;
    logic       busy8, done8, bout8;
    logic [7:0] diff8;

    logic       start1;
    logic [0:0] a1, b1;
    logic       busy1, done1, bout1;
    logic [0:0] diff1;

    int total;
    int passed;

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .diff(diff8), .bout(bout8)
    );

    serial_subtractor #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1),
        .busy(busy1), .done(done1), .diff(diff1), .bout(bout1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    // Runs one 8-bit operation; lat = edges from start edge to done,
    // bc = negedge samples with busy high from start edge through done.
    task automatic op8(input logic [7:0] ta, input logic [7:0] tb_v, output int lat, output int bc);
        @(negedge clk);
        a8 = ta; b8 = tb_v; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        lat = 0;
        bc = busy8 ? 1 : 0;
        while (!done8 && lat < 40) begin
            @(negedge clk);
            lat++;
            if (busy8) bc++;
        end
    endtask

    task automatic op1(input logic ta, input logic tb_v, output int lat);
        @(negedge clk);
        a1 = ta; b1 = tb_v; start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        lat = 0;
        while (!done1 && lat < 10) begin
            @(negedge clk);
            lat++;
        end
    endtask

    initial begin
        int lat, bc, pulses;
        total = 0; passed = 0;
        rst_n = 1'b0;
        start8 = 1'b0; a8 = '0; b8 = '0;
        start1 = 1'b0; a1 = '0; b1 = '0;
        repeat (3) @(negedge clk);

        check("rst_busy", busy8, 0);
        check("rst_done", done8, 0);
        check("rst_diff", diff8, 0);
        check("rst_bout", bout8, 0);
        check("rst_diff_w1", diff1, 0);
        rst_n = 1'b1;

        // 200 - 55
        op8(8'd200, 8'd55, lat, bc);
        check("t1_latency", lat, 8);
        check("t1_busy_cycles", bc, 9);
        check("t1_diff", diff8, 145);
        check("t1_bout", bout8, 0);
        @(negedge clk);
        check("t1_done_fall", done8, 0);
        check("t1_busy_fall", busy8, 0);

        op8(8'd55, 8'd200, lat, bc);
        check("t2_diff", diff8, 8'h6F);
        check("t2_bout", bout8, 1);
        op8(8'h00, 8'h01, lat, bc);
        check("t2b_diff", diff8, 8'hFF);
        check("t2b_bout", bout8, 1);

        op8(8'hAA, 8'hAA, lat, bc);
        check("t3_diff", diff8, 8'h00);
        check("t3_bout", bout8, 0);
        op8(8'hFF, 8'h00, lat, bc);
        check("t3b_diff", diff8, 8'hFF);
        check("t3b_bout", bout8, 0);

        // Starts while busy are ignored; start right after DONE is accepted.
        @(negedge clk);
        @(negedge clk);
        a8 = 8'd10; b8 = 8'd3; start8 = 1'b1;
        pulses = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (done8) begin
                pulses++;
                check("t4_diff", diff8, 7);
                check("t4_bout", bout8, 0);
            end
            if (k == 3 || k == 9 || k == 10) begin
                a8 = 8'd100; b8 = 8'd1; start8 = 1'b1;
            end else begin
                start8 = 1'b0;
            end
        end
        check("t4_done_pulses", pulses, 1);
        @(negedge clk);
        start8 = 1'b0;
        check("t4_restart_busy", busy8, 1);
        lat = 0;
        while (!done8 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check("t4_restart_diff", diff8, 99);
        check("t4_restart_bout", bout8, 0);

        // Reset mid-operation after a borrowing result so outputs are nonzero.
        op8(8'd1, 8'd2, lat, bc);
        check("t5_pre_bout", bout8, 1);
        @(negedge clk);
        a8 = 8'd200; b8 = 8'd55; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("t5_busy", busy8, 0);
        check("t5_done", done8, 0);
        check("t5_diff", diff8, 0);
        check("t5_bout", bout8, 0);
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (done8) pulses++;
        end
        check("t5_no_done", pulses, 0);
        op8(8'd9, 8'd4, lat, bc);
        check("t5_fresh_diff", diff8, 5);
        check("t5_fresh_bout", bout8, 0);

        // WIDTH=1 truth table
        op1(1'b0, 1'b0, lat);
        check("w1_00_lat", lat, 1);
        check("w1_00_diff", diff1, 0);
        check("w1_00_bout", bout1, 0);
        op1(1'b0, 1'b1, lat);
        check("w1_01_diff", diff1, 1);
        check("w1_01_bout", bout1, 1);
        op1(1'b1, 1'b0, lat);
        check("w1_10_diff", diff1, 1);
        check("w1_10_bout", bout1, 0);
        op1(1'b1, 1'b1, lat);
        check("w1_11_lat", lat, 1);
        check("w1_11_diff", diff1, 0);
        check("w1_11_bout", bout1, 0);
        @(negedge clk);
        check("w1_done_fall", done1, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
